// File: rtl/cpu_pkg.sv
// Shared definitions for the 16-bit core's decode-stage hazard logic:
// register address width, forwarding mux encodings, halt states and shadow entries.
package cpu_pkg;

  localparam int ADDR_W = 4;

  localparam logic [1:0] FWD_RF  = 2'b00;
  localparam logic [1:0] FWD_MEM = 2'b01;
  localparam logic [1:0] FWD_WB  = 2'b10;

  typedef enum logic [1:0] {
    RUN,
    DRAIN,
    HALTED
  } halt_state_e;

  typedef struct packed {
    logic              valid;
    logic [ADDR_W-1:0] dst;
    logic              we;
    logic              load;
  } hz_entry_t;

  // r0 is hardwired zero, so a write to it never creates a dependency.
  function automatic logic hz_match(hz_entry_t e, logic use_src, logic [ADDR_W-1:0] src);
    return use_src & e.valid & e.we & (e.dst == src) & (src != '0);
  endfunction

  function automatic logic [1:0] fwd_sel(hz_entry_t ex, hz_entry_t mem,
                                         logic use_src, logic [ADDR_W-1:0] src);
    if (hz_match(ex, use_src, src))
      return FWD_MEM;
    else if (hz_match(mem, use_src, src))
      return FWD_WB;
    else
      return FWD_RF;
  endfunction

endpackage

// File: rtl/hz_stage_reg.sv
// One pipeline-stage shadow entry {valid, dst, we, load}.
// hold freezes the entry; clear loads an invalid entry (bubble/squash).
module hz_stage_reg
  import cpu_pkg::*;
(
  input  logic      clk,
  input  logic      rst,
  input  logic      hold,
  input  logic      clear,
  input  hz_entry_t d,
  output hz_entry_t q
);

  always_ff @(posedge clk) begin
    if (rst)
      q <= '0;
    else if (!hold) begin
      if (clear)
        q <= '0;
      else
        q <= d;
    end
  end

endmodule

// File: rtl/id_hazard_ctrl.sv
// Decode-stage hazard controller: RF read port drive, forwarding selects,
// load-use stalls and the halt drain sequence that ends in an RF dump.
module id_hazard_ctrl
  import cpu_pkg::*;
#(
  parameter int DRAIN_CYCLES = 3
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              id_valid,
  input  logic [ADDR_W-1:0] id_src0,
  input  logic [ADDR_W-1:0] id_src1,
  input  logic              id_use0,
  input  logic              id_use1,
  input  logic [ADDR_W-1:0] id_dst,
  input  logic              id_we,
  input  logic              id_load,
  input  logic              id_hlt,
  input  logic              flush,
  input  logic              mem_stall,
  output logic [ADDR_W-1:0] rf_p0_addr,
  output logic [ADDR_W-1:0] rf_p1_addr,
  output logic              rf_re0,
  output logic              rf_re1,
  output logic              stall,
  output logic              ex_bubble,
  output logic [1:0]        fwd0_sel,
  output logic [1:0]        fwd1_sel,
  output logic              hlt_rf
);

  localparam int CNT_W = $clog2(DRAIN_CYCLES + 1);

  halt_state_e      state, state_next;
  logic [CNT_W-1:0] cnt, cnt_next;
  logic             halting, load_use, id_accept, hlt_q;
  logic [1:0]       fwd0_q, fwd1_q;
  hz_entry_t        id_entry;
  hz_entry_t        stage_q [3];  // 0 = EX, 1 = MEM, 2 = WB

  assign halting    = (state != RUN);
  assign rf_p0_addr = id_src0;
  assign rf_p1_addr = id_src1;
  assign rf_re0     = id_valid & id_use0 & ~halting;
  assign rf_re1     = id_valid & id_use1 & ~halting;

  // A load in EX has no result until the end of MEM, so a dependent ID must wait one cycle.
  assign load_use  = id_valid & ~halting & ~flush & stage_q[0].load &
                     (hz_match(stage_q[0], id_use0, id_src0) |
                      hz_match(stage_q[0], id_use1, id_src1));
  assign stall     = halting | load_use;
  assign ex_bubble = load_use & ~mem_stall;
  assign id_accept = id_valid & ~halting & ~flush & ~load_use;

  always_comb begin
    id_entry       = '0;
    id_entry.valid = id_accept;
    id_entry.dst   = id_dst;
    id_entry.we    = id_we;
    id_entry.load  = id_load;
  end

  for (genvar i = 0; i < 3; i++) begin : g_stage
    if (i == 0) begin : g_ex
      hz_stage_reg u_stage (
        .clk  (clk),
        .rst  (rst),
        .hold (mem_stall),
        .clear(~id_accept),
        .d    (id_entry),
        .q    (stage_q[0])
      );
    end else begin : g_tail
      hz_stage_reg u_stage (
        .clk  (clk),
        .rst  (rst),
        .hold (mem_stall),
        .clear(1'b0),
        .d    (stage_q[i-1]),
        .q    (stage_q[i])
      );
    end
  end

  // A WB producer needs no select: the RF writes in the high phase and reads in the low phase.
  always_ff @(posedge clk) begin
    if (rst) begin
      fwd0_q <= FWD_RF;
      fwd1_q <= FWD_RF;
    end else if (!mem_stall) begin
      fwd0_q <= id_accept ? fwd_sel(stage_q[0], stage_q[1], id_use0, id_src0) : FWD_RF;
      fwd1_q <= id_accept ? fwd_sel(stage_q[0], stage_q[1], id_use1, id_src1) : FWD_RF;
    end
  end

  assign fwd0_sel = fwd0_q;
  assign fwd1_sel = fwd1_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      state <= RUN;
      cnt   <= '0;
      hlt_q <= 1'b0;
    end else begin
      state <= state_next;
      cnt   <= cnt_next;
      hlt_q <= (state_next == HALTED);
    end
  end

  // cnt tracks the HLT's remaining trip to the end of WB; frozen cycles do not count.
  always_comb begin
    state_next = state;
    cnt_next   = cnt;
    case (state)
      RUN: begin
        if (id_valid & id_hlt & ~stall & ~flush & ~mem_stall) begin
          state_next = DRAIN;
          cnt_next   = CNT_W'(DRAIN_CYCLES);
        end
      end
      DRAIN: begin
        if (!mem_stall) begin
          if (cnt == CNT_W'(1))
            state_next = HALTED;
          else
            cnt_next = cnt - CNT_W'(1);
        end
      end
      HALTED: state_next = HALTED;
      default: state_next = RUN;
    endcase
  end

  assign hlt_rf = hlt_q;

endmodule
